branch_pred_scoreboard: RTL and testbench

- Downstream monitor for the branch predictor. Watches the predictor's request inputs (new-data strobe, ground-truth direction, instruction low byte) and its status outputs (pred_ready, prediction, training_done, mem_reset_done).
- Scores each branch transaction as correct or mispredicted, keeps saturating performance counters and a windowed accuracy figure, and flags protocol violations.
- Used on-chip for self-characterisation and in benches as a checker.

---
 rtl/branch_pred_scoreboard.sv | 173 +++++++++++++++++
 tb/tb_branch_pred_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_scoreboard.sv
// Branch predictor monitor: scores each request/prediction/training transaction,
// keeps saturating performance counters and a windowed accuracy figure, and flags protocol errors.
module branch_pred_scoreboard #(
   parameter int CNT_W   = 16,
   parameter int WIN_LEN = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       new_data_avail,
   input  logic                       direction_ground_truth,
   input  logic [7:0]                 inst_lowest_byte,
   input  logic                       mem_reset_done,
   input  logic                       pred_ready,
   input  logic                       prediction,
   input  logic                       training_done,
   output logic [CNT_W-1:0]           total_cnt,
   output logic [CNT_W-1:0]           miss_cnt,
   output logic [CNT_W-1:0]           best_streak,
   output logic [$clog2(WIN_LEN):0]   win_correct,
   output logic                       win_valid,
   output logic [7:0]                 last_addr,
   output logic                       busy,
   output logic                       err_timeout,
   output logic                       err_overlap
);

   localparam int WIN_W = $clog2(WIN_LEN);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {WAIT_INIT, IDLE, WAIT_PRED, WAIT_TRAIN} state_t;

   state_t             state;
   logic               nda_q;
   logic               truth_q;
   logic               pred_q;
   logic [7:0]         addr_q;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [CNT_W-1:0]   cur_streak;
   logic [WIN_W-1:0]   win_idx;
   logic [WIN_W:0]     win_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic               req_edge;
   logic               score_now;
   logic               score_pred;
   logic               correct;
   logic [TMO_W-1:0]   tmo_next;
   logic               tmo_hit;
   logic [CNT_W-1:0]   streak_inc;
   logic [WIN_W:0]     win_cnt_next;

   assign req_edge     = new_data_avail & ~nda_q;
   // Scoring requires the predictor to still be initialised; a dropped mem_reset_done aborts instead.
   assign score_now    = mem_reset_done &
                         (((state == WAIT_PRED) & pred_ready & training_done) |
                          ((state == WAIT_TRAIN) & training_done));
   assign score_pred   = (state == WAIT_PRED) ? prediction : pred_q;
   assign correct      = (score_pred == truth_q);
   assign tmo_next     = tmo_cnt + TMO_W'(1);
   assign tmo_hit      = (tmo_next == TMO_W'(TIMEOUT));
   assign streak_inc   = sat_inc(cur_streak);
   assign win_cnt_next = win_cnt + {{WIN_W{1'b0}}, correct};
   assign busy         = (state == WAIT_PRED) | (state == WAIT_TRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= WAIT_INIT;
         nda_q       <= 1'b0;
         truth_q     <= 1'b0;
         pred_q      <= 1'b0;
         addr_q      <= '0;
         tmo_cnt     <= '0;
         cur_streak  <= '0;
         win_idx     <= '0;
         win_cnt     <= '0;
         total_cnt   <= '0;
         miss_cnt    <= '0;
         best_streak <= '0;
         win_correct <= '0;
         win_valid   <= 1'b0;
         last_addr   <= '0;
         err_timeout <= 1'b0;
         err_overlap <= 1'b0;
      end else begin
         nda_q     <= new_data_avail;
         win_valid <= 1'b0;

         case (state)
            WAIT_INIT: begin
               if (mem_reset_done) state <= IDLE;
            end
            IDLE: begin
               if (!mem_reset_done) begin
                  state <= WAIT_INIT;
               end else if (req_edge) begin
                  truth_q <= direction_ground_truth;
                  addr_q  <= inst_lowest_byte;
                  tmo_cnt <= '0;
                  state   <= WAIT_PRED;
               end
            end
            default: begin
               if (!mem_reset_done) begin
                  state <= WAIT_INIT;
               end else if (score_now) begin
                  if (req_edge) begin
                     truth_q <= direction_ground_truth;
                     addr_q  <= inst_lowest_byte;
                     tmo_cnt <= '0;
                     state   <= WAIT_PRED;
                  end else begin
                     state <= IDLE;
                  end
               end else if (req_edge) begin
                  err_overlap <= 1'b1;
                  truth_q     <= direction_ground_truth;
                  addr_q      <= inst_lowest_byte;
                  tmo_cnt     <= '0;
                  state       <= WAIT_PRED;
               end else if ((state == WAIT_PRED) && pred_ready) begin
                  pred_q  <= prediction;
                  tmo_cnt <= tmo_next;
                  state   <= WAIT_TRAIN;
               end else if (tmo_hit) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
         endcase

         // Clear is placed last so it overrides both scoring and error setting in the same cycle.
         if (clear) begin
            total_cnt   <= '0;
            miss_cnt    <= '0;
            best_streak <= '0;
            cur_streak  <= '0;
            win_idx     <= '0;
            win_cnt     <= '0;
            win_correct <= '0;
            win_valid   <= 1'b0;
            err_timeout <= 1'b0;
            err_overlap <= 1'b0;
         end else if (score_now) begin
            total_cnt <= sat_inc(total_cnt);
            last_addr <= addr_q;
            if (!correct) begin
               miss_cnt   <= sat_inc(miss_cnt);
               cur_streak <= '0;
            end else begin
               cur_streak <= streak_inc;
               if (streak_inc > best_streak) best_streak <= streak_inc;
            end
            if (win_idx == WIN_W'(WIN_LEN - 1)) begin
               win_correct <= win_cnt_next;
               win_valid   <= 1'b1;
               win_idx     <= '0;
               win_cnt     <= '0;
            end else begin
               win_idx <= win_idx + WIN_W'(1);
               win_cnt <= win_cnt_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_pred_scoreboard.sv
// Bench for branch_pred_scoreboard: default build checked through a scoreboard queue,
// plus a CNT_W=4 build sharing the stimulus for saturation.
module tb_branch_pred_scoreboard;

   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, clr_a, clr_b, nda, truth, mrd, pred_ready, prediction, training_done;
   logic [7:0] addr;

   logic [15:0] total_cnt, miss_cnt, best_streak;
   logic [5:0]  win_correct;
   logic        win_valid, busy, err_timeout, err_overlap;
   logic [7:0]  last_addr;

   logic [3:0]  s_total, s_miss, s_best;
   logic [5:0]  s_win_correct;
   logic        s_win_valid, s_busy, s_err_timeout, s_err_overlap;
   logic [7:0]  s_last_addr;

   branch_pred_scoreboard u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clr_a), .new_data_avail(nda),
      .direction_ground_truth(truth), .inst_lowest_byte(addr), .mem_reset_done(mrd),
      .pred_ready(pred_ready), .prediction(prediction), .training_done(training_done),
      .total_cnt(total_cnt), .miss_cnt(miss_cnt), .best_streak(best_streak),
      .win_correct(win_correct), .win_valid(win_valid), .last_addr(last_addr),
      .busy(busy), .err_timeout(err_timeout), .err_overlap(err_overlap));

   branch_pred_scoreboard #(.CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .clear(clr_b), .new_data_avail(nda),
      .direction_ground_truth(truth), .inst_lowest_byte(addr), .mem_reset_done(mrd),
      .pred_ready(pred_ready), .prediction(prediction), .training_done(training_done),
      .total_cnt(s_total), .miss_cnt(s_miss), .best_streak(s_best),
      .win_correct(s_win_correct), .win_valid(s_win_valid), .last_addr(s_last_addr),
      .busy(s_busy), .err_timeout(s_err_timeout), .err_overlap(s_err_overlap));

   typedef struct {
      logic [15:0] total;
      logic [15:0] miss;
      logic [15:0] best;
      logic [7:0]  addr;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_total, m_miss, m_streak, m_best;
   logic cur_t;
   logic [7:0] cur_a;
   int   win_pulses;
   int   win_total_at;
   logic [15:0] prev_total = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output side of the scoreboard: every increase of total_cnt consumes one expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (win_valid) begin
            win_pulses++;
            win_total_at = total_cnt;
         end
         if (total_cnt > prev_total) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_score", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_total", total_cnt, e.total);
               chk("sb_miss", miss_cnt, e.miss);
               chk("sb_best", best_streak, e.best);
               chk("sb_addr", last_addr, e.addr);
            end
         end
         prev_total = total_cnt;
      end
   end

   task automatic model_reset();
      m_total = 0; m_miss = 0; m_streak = 0; m_best = 0;
   endtask

   task automatic req(input logic t, input logic [7:0] a);
      @(posedge clk); #1;
      nda = 1'b1; truth = t; addr = a; cur_t = t; cur_a = a;
      @(posedge clk); #1;
      nda = 1'b0;
   endtask

   task automatic respond(input logic p, input logic same);
      exp_t e;
      m_total++;
      if (p != cur_t) begin
         m_miss++; m_streak = 0;
      end else begin
         m_streak++;
         if (m_streak > m_best) m_best = m_streak;
      end
      e.total = 16'(m_total); e.miss = 16'(m_miss); e.best = 16'(m_best); e.addr = cur_a;
      sb_q.push_back(e);
      pred_ready = 1'b1; prediction = p; training_done = same;
      @(posedge clk); #1;
      pred_ready = 1'b0; training_done = 1'b0;
      if (!same) begin
         training_done = 1'b1;
         @(posedge clk); #1;
         training_done = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic p, input logic t, input logic [7:0] a);
      req(t, a);
      @(posedge clk); #1;
      respond(p, 1'b0);
   endtask

   task automatic clr(input logic a, input logic b);
      @(posedge clk); #1;
      clr_a = a; clr_b = b;
      @(posedge clk); #1;
      clr_a = 1'b0; clr_b = 1'b0;
      if (a) model_reset();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0; nda = 1'b0; truth = 1'b0; addr = '0;
      mrd = 1'b0; pred_ready = 1'b0; prediction = 1'b0; training_done = 1'b0;
      cur_t = 1'b0; cur_a = '0; win_pulses = 0; win_total_at = 0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_total", total_cnt, 0);
      chk("rst_miss", miss_cnt, 0);
      chk("rst_best", best_streak, 0);
      chk("rst_win_correct", win_correct, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_last_addr", last_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_timeout, err_overlap}, 0);
      @(posedge clk); #1 mrd = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Four basic transactions
      txn(1'b1, 1'b1, 8'h10);
      txn(1'b0, 1'b1, 8'h20);
      txn(1'b1, 1'b1, 8'h30);
      txn(1'b1, 1'b1, 8'h4C);
      chk("t1_total", total_cnt, 4);
      chk("t1_miss", miss_cnt, 1);
      chk("t1_best", best_streak, 2);
      chk("t1_last_addr", last_addr, 8'h4C);
      chk("t1_errs", {err_timeout, err_overlap}, 0);

      // One full accuracy window with five mispredictions
      clr(1'b1, 1'b1);
      win_pulses = 0; win_total_at = 0;
      for (int i = 0; i < 32; i++) begin
         logic t;
         t = i[0];
         txn(((i % 6) == 3) ? ~t : t, t, 8'(i + 8'h80));
      end
      chk("win_pulses", win_pulses, 1);
      chk("win_at_total", win_total_at, 32);
      chk("win_correct", win_correct, 27);
      chk("win_best", best_streak, 5);

      // Timeout with pred_ready withheld
      req(1'b1, 8'h33);
      chk("tmo_busy_wait", busy, 1);
      repeat (TIMEOUT + 4) @(posedge clk);
      #1;
      chk("tmo_err", err_timeout, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_total", total_cnt, 16'(m_total));
      txn(1'b0, 1'b0, 8'h34);
      chk("tmo_next_total", total_cnt, 33);

      // Overlapping request while waiting for a prediction
      req(1'b0, 8'h11);
      repeat (3) @(posedge clk);
      #1;
      req(1'b1, 8'h22);
      respond(1'b1, 1'b0);
      chk("ovl_err", err_overlap, 1);
      chk("ovl_total", total_cnt, 34);
      chk("ovl_addr", last_addr, 8'h22);

      // Prediction and training complete in the same cycle
      clr(1'b1, 1'b0);
      chk("clr_errs", {err_timeout, err_overlap}, 0);
      req(1'b0, 8'h5A);
      m_total++; m_streak++; if (m_streak > m_best) m_best = m_streak;
      sb_q.push_back('{total: 16'(m_total), miss: 16'(m_miss), best: 16'(m_best), addr: 8'h5A});
      pred_ready = 1'b1; prediction = 1'b0; training_done = 1'b1;
      @(posedge clk); #1;
      pred_ready = 1'b0; training_done = 1'b0;
      chk("same_total_next", total_cnt, 1);
      chk("same_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;

      // mem_reset_done dropped mid-transaction
      req(1'b1, 8'hA5);
      repeat (2) @(posedge clk);
      #1 mrd = 1'b0;
      @(posedge clk); #1;
      chk("mrd_busy", busy, 0);
      pred_ready = 1'b1; prediction = 1'b1; training_done = 1'b1;
      @(posedge clk); #1;
      pred_ready = 1'b0; training_done = 1'b0; mrd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mrd_total", total_cnt, 1);
      chk("mrd_errs", {err_timeout, err_overlap}, 0);
      chk("mrd_last_addr", last_addr, 8'h5A);
      txn(1'b1, 1'b1, 8'hA6);
      chk("mrd_next_total", total_cnt, 2);

      // Saturation on the narrow build, then a global clear
      clr(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) txn(1'b1, 1'b1, 8'(i));
      chk("sat_total", s_total, 15);
      chk("sat_best", s_best, 15);
      chk("sat_miss", s_miss, 0);
      chk("sat_wide_total", total_cnt, 22);
      clr(1'b1, 1'b1);
      chk("clr_total", total_cnt, 0);
      chk("clr_miss", miss_cnt, 0);
      chk("clr_best", best_streak, 0);
      chk("clr_win_correct", win_correct, 0);
      chk("clr_small_total", s_total, 0);
      chk("clr_small_best", s_best, 0);

      chk("sb_drain", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
